cbudl_mod3q: RTL and testbench



---
 rtl/cnt_pkg.sv | 19 +
 rtl/vote.sv | 13 +
 rtl/cbudl_mod3q.sv | 139 +++++++++++++
 tb/tb_cbudl_mod3q.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the cbudl_mod3q up/down counter: mode encodings and
// the terminal-value helper used to size the count range.
package cnt_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Largest reachable count; evaluated at 64 bits so Modulus = 2^Width is safe.
    function automatic logic [32:0] cnt_max(input int width, input longint modulus);
        logic [63:0] m;
        if (modulus == 64'd0) begin
            m = (64'd1 << width) - 64'd1;
        end else begin
            m = modulus - 64'd1;
        end
        return m[32:0];
    endfunction

endpackage

// File: rtl/vote.sv
// Bitwise 2-of-3 majority voter used to recover the count from three replicas.
module vote #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic [Width-1:0] C,
    output logic [Width-1:0] V
);

    assign V = (A & B) | (B & C) | (A & C);

endmodule

// File: rtl/cbudl_mod3q.sv
// Up/down counter with load, programmable modulus, wrap/saturate and optional
// TMR storage. Define CBUDL_TMR_ERR_EN to enable the sticky replica-mismatch ERR flag.
module cbudl_mod3q
    import cnt_pkg::*;
#(
    parameter int     Width   = 8,
    parameter longint Modulus = 0,
    parameter int     Mode    = MODE_WRAP,
    parameter int     TMR     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [Width-1:0] D,
    output logic [Width-1:0] Q1,
    output logic [Width-1:0] Q2,
    output logic [Width-1:0] Q3,
    output logic             TC,
    output logic             OVF,
    output logic             ERR
);

    localparam logic [Width-1:0] MAX = Width'(cnt_max(Width, Modulus));
    localparam logic [Width-1:0] ONE = Width'(1);

    logic [Width-1:0] v;
    logic [Width-1:0] cnt_d;
    logic             ovf_d;
    logic             ovf_q;

    // Next value is derived from the voted count only, so every edge rewrites
    // all replicas with the same value and scrubs any single upset.
    always_comb begin
        cnt_d = v;
        ovf_d = 1'b0;
        if (LOAD) begin
            cnt_d = ({1'b0, D} > {1'b0, MAX}) ? MAX : D;
        end else if (CE) begin
            if (UP) begin
                if (v == MAX) begin
                    ovf_d = 1'b1;
                    cnt_d = (Mode == MODE_SAT) ? MAX : '0;
                end else begin
                    cnt_d = v + ONE;
                end
            end else begin
                if (v == '0) begin
                    ovf_d = 1'b1;
                    cnt_d = (Mode == MODE_SAT) ? '0 : MAX;
                end else begin
                    cnt_d = v - ONE;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
    assign TC  = UP ? (v == MAX) : (v == '0);

    if (TMR != 0) begin : g_tmr
        logic [Width-1:0] cnt1_q;
        logic [Width-1:0] cnt2_q;
        logic [Width-1:0] cnt3_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt1_q <= '0;
                cnt2_q <= '0;
                cnt3_q <= '0;
            end else begin
                cnt1_q <= cnt_d;
                cnt2_q <= cnt_d;
                cnt3_q <= cnt_d;
            end
        end

        vote #(.Width(Width)) u_vote (
            .A(cnt1_q),
            .B(cnt2_q),
            .C(cnt3_q),
            .V(v)
        );

        assign Q1 = cnt1_q;
        assign Q2 = cnt2_q;
        assign Q3 = cnt3_q;

`ifdef CBUDL_TMR_ERR_EN
        logic err_d;
        logic err_q;
        logic mismatch;

        assign mismatch = |((cnt1_q ^ cnt2_q) | (cnt2_q ^ cnt3_q));

        always_comb begin
            err_d = err_q | mismatch;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_d;
            end
        end

        assign ERR = err_q;
`else
        assign ERR = 1'b0;
`endif
    end else begin : g_single
        logic [Width-1:0] cnt_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign v   = cnt_q;
        assign Q1  = cnt_q;
        assign Q2  = cnt_q;
        assign Q3  = cnt_q;
        assign ERR = 1'b0;
    end

endmodule

// File: tb/tb_cbudl_mod3q.sv
// Bench for cbudl_mod3q: three configurations driven in lockstep and checked
// against a behavioural model of the counting rules.
module tb_cbudl_mod3q;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       up;
    logic       load;
    logic [7:0] d;
    logic [3:0] d4;

    logic [7:0] w_q1, w_q2, w_q3;
    logic       w_tc, w_ovf, w_err;
    logic [3:0] s_q1, s_q2, s_q3;
    logic       s_tc, s_ovf, s_err;
    logic [7:0] t_q1, t_q2, t_q3;
    logic       t_tc, t_ovf, t_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: count, pending OVF and expected ERR per configuration.
    int m_w, m_s, m_t;
    bit o_w, o_s, o_t;
    bit e_t;

    localparam int MAX_W = 9;
    localparam int MAX_S = 15;
    localparam int MAX_T = 255;

    assign d4 = d[3:0];

    always #5 clk = ~clk;

    cbudl_mod3q #(.Width(8), .Modulus(10), .Mode(0), .TMR(0)) dut_w (
        .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LOAD(load), .D(d),
        .Q1(w_q1), .Q2(w_q2), .Q3(w_q3), .TC(w_tc), .OVF(w_ovf), .ERR(w_err)
    );

    cbudl_mod3q #(.Width(4), .Modulus(0), .Mode(1), .TMR(0)) dut_s (
        .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LOAD(load), .D(d4),
        .Q1(s_q1), .Q2(s_q2), .Q3(s_q3), .TC(s_tc), .OVF(s_ovf), .ERR(s_err)
    );

    cbudl_mod3q #(.Width(8), .Modulus(0), .Mode(0), .TMR(1)) dut_t (
        .CLK(clk), .RST(rst), .CE(ce), .UP(up), .LOAD(load), .D(d),
        .Q1(t_q1), .Q2(t_q2), .Q3(t_q3), .TC(t_tc), .OVF(t_ovf), .ERR(t_err)
    );

    function automatic void ref_next(inout int v, output bit ovf, input bit l, input bit c,
                                     input bit u, input int dv, input int maxv, input bit sat);
        ovf = 1'b0;
        if (l) begin
            v = (dv > maxv) ? maxv : dv;
        end else if (c && u) begin
            if (v == maxv) begin
                ovf = 1'b1;
                v = sat ? maxv : 0;
            end else begin
                v = v + 1;
            end
        end else if (c) begin
            if (v == 0) begin
                ovf = 1'b1;
                v = sat ? 0 : maxv;
            end else begin
                v = v - 1;
            end
        end
    endfunction

    function automatic bit ref_tc(input int v, input int maxv, input bit u);
        return u ? (v == maxv) : (v == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " w.q1"}, 32'(w_q1), 32'(m_w));
        chk({tag, " w.q2"}, 32'(w_q2), 32'(m_w));
        chk({tag, " w.q3"}, 32'(w_q3), 32'(m_w));
        chk({tag, " w.tc"}, 32'(w_tc), 32'(ref_tc(m_w, MAX_W, up)));
        chk({tag, " w.ovf"}, 32'(w_ovf), 32'(o_w));
        chk({tag, " w.err"}, 32'(w_err), 32'd0);
        chk({tag, " s.q1"}, 32'(s_q1), 32'(m_s));
        chk({tag, " s.q3"}, 32'(s_q3), 32'(m_s));
        chk({tag, " s.tc"}, 32'(s_tc), 32'(ref_tc(m_s, MAX_S, up)));
        chk({tag, " s.ovf"}, 32'(s_ovf), 32'(o_s));
        chk({tag, " s.err"}, 32'(s_err), 32'd0);
        chk({tag, " t.q1"}, 32'(t_q1), 32'(m_t));
        chk({tag, " t.q2"}, 32'(t_q2), 32'(m_t));
        chk({tag, " t.q3"}, 32'(t_q3), 32'(m_t));
        chk({tag, " t.tc"}, 32'(t_tc), 32'(ref_tc(m_t, MAX_T, up)));
        chk({tag, " t.ovf"}, 32'(t_ovf), 32'(o_t));
        chk({tag, " t.err"}, 32'(t_err), 32'(e_t));
    endtask

    // Inputs are applied after a falling edge; results are checked on the next falling edge.
    task automatic step(input bit l, input bit c, input bit u, input logic [7:0] dv,
                        input string tag);
        load = l;
        ce   = c;
        up   = u;
        d    = dv;
        @(posedge clk);
        ref_next(m_w, o_w, l, c, u, int'(dv), MAX_W, 1'b0);
        ref_next(m_s, o_s, l, c, u, int'(dv[3:0]), MAX_S, 1'b1);
        ref_next(m_t, o_t, l, c, u, int'(dv), MAX_T, 1'b0);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic model_reset();
        m_w = 0; m_s = 0; m_t = 0;
        o_w = 0; o_s = 0; o_t = 0;
        e_t = 0;
    endtask

    initial begin
        rst  = 1'b1;
        ce   = 1'b0;
        up   = 1'b0;
        load = 1'b0;
        d    = 8'h00;
        model_reset();

        // Reset state visible before any clock edge.
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Load and clamp.
        step(1, 0, 0, 8'h05, "load5");
        step(1, 0, 0, 8'h0F, "load_clamp");

        // Wrap up through the end of range.
        step(1, 0, 1, 8'h08, "load8");
        step(0, 1, 1, 8'h00, "up1");
        step(0, 1, 1, 8'h00, "up2");
        step(0, 1, 1, 8'h00, "up3");

        // Wrap down from zero.
        step(1, 0, 0, 8'h00, "load0");
        step(0, 1, 0, 8'h00, "down_wrap");
        step(0, 0, 0, 8'h00, "idle");

        // Saturation at the top, repeated OVF while held.
        step(1, 0, 1, 8'h0E, "load14");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 8'h00, "sat_up");
        step(0, 0, 1, 8'h00, "sat_idle");

        // Saturation at the bottom.
        step(1, 0, 0, 8'h01, "load1");
        step(0, 1, 0, 8'h00, "sat_dn1");
        step(0, 1, 0, 8'h00, "sat_dn2");

        // LOAD beats CE, then hold.
        step(1, 0, 1, 8'h07, "load7");
        step(1, 1, 1, 8'h03, "load_prio");
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00, "hold");

        // Single-replica upset is scrubbed on the next edge.
        step(1, 0, 0, 8'h10, "load10h");
        force dut_t.g_tmr.cnt2_q = 8'hAA;
        #1;
        chk("upset t.q2", 32'(t_q2), 32'h0000_00AA);
        chk("upset t.q1", 32'(t_q1), 32'h0000_0010);
        release dut_t.g_tmr.cnt2_q;
`ifdef CBUDL_TMR_ERR_EN
        e_t = 1'b1;
`endif
        step(0, 0, 0, 8'h00, "scrub");
        step(0, 0, 0, 8'h00, "scrub_hold");

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            bit         rl, rc, ru;
            logic [7:0] rd;
            rl = ($urandom_range(0, 11) == 0);
            rc = ($urandom_range(0, 3) != 0);
            ru = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(0, 16));
            step(rl, rc, ru, rd, "rand");
        end

        // Asynchronous reset mid-count right after a wrap event.
        step(1, 0, 1, 8'h09, "pre_rst_load");
        step(0, 1, 1, 8'h00, "pre_rst_wrap");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 1, 8'h00, "post_rst_up");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
